// File: rtl/cross_arbiter.sv
// cross_arbiter: round-robin arbiter for two requesters sharing one signed
// 11x11 multiplier that computes the 2-D cross product ax*by - ay*bx.
// One service takes four cycles: IDLE (grant/latch), MUL1, MUL2, DONE (ack).
module cross_arbiter (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic signed [10:0] ax0,
  input  logic signed [10:0] ay0,
  input  logic signed [10:0] bx0,
  input  logic signed [10:0] by0,
  input  logic signed [10:0] ax1,
  input  logic signed [10:0] ay1,
  input  logic signed [10:0] bx1,
  input  logic signed [10:0] by1,
  output logic               ack0,
  output logic               ack1,
  output logic signed [22:0] result,
  output logic               neg,
  output logic               zero,
  output logic               busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL1 = 2'd1;
  localparam logic [1:0] MUL2 = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic               last_served;
  logic               grant;
  logic               win;
  logic signed [10:0] ax_q;
  logic signed [10:0] ay_q;
  logic signed [10:0] bx_q;
  logic signed [10:0] by_q;
  logic signed [21:0] temp;
  logic signed [10:0] mul_a;
  logic signed [10:0] mul_b;
  logic signed [21:0] product;
  logic signed [22:0] diff;

  // Round-robin pick: on a tie the requester not served last wins,
  // otherwise whichever requester is asking wins.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = ~last_served;
    end else if (req0) begin
      win = 1'b0;
    end else begin
      win = 1'b1;
    end
  end

  // Steer the latched operands into the single shared multiplier:
  // ax*by during MUL1, ay*bx during MUL2.
  always_comb begin
    mul_a = ay_q;
    mul_b = bx_q;
    if (state == MUL1) begin
      mul_a = ax_q;
      mul_b = by_q;
    end
  end

  // The product of two 11-bit signed values always fits in 22 bits,
  // and the difference of two such products always fits in 23 bits.
  assign product = 22'(mul_a) * 22'(mul_b);
  assign diff    = 23'(temp) - 23'(product);
  assign busy    = (state != IDLE);

  // Main sequencer: grant and latch operands, run both multiplies,
  // register the result with its flags and pulse the winner's ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      grant       <= 1'b0;
      ax_q        <= '0;
      ay_q        <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      temp        <= '0;
      result      <= '0;
      neg         <= 1'b0;
      zero        <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant       <= win;
            last_served <= win;
            ax_q        <= win ? ax1 : ax0;
            ay_q        <= win ? ay1 : ay0;
            bx_q        <= win ? bx1 : bx0;
            by_q        <= win ? by1 : by0;
            state       <= MUL1;
          end
        end
        MUL1: begin
          temp  <= product;
          state <= MUL2;
        end
        MUL2: begin
          result <= diff;
          neg    <= diff[22];
          zero   <= (diff == 23'sd0);
          ack0   <= ~grant;
          ack1   <= grant;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cross_arbiter.sv
// tb_cross_arbiter: directed self-checking bench for cross_arbiter with
// hand-computed cross products, arbitration order and reset behaviour.
module tb_cross_arbiter;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               req0 = 1'b0;
  logic               req1 = 1'b0;
  logic signed [10:0] ax0 = '0;
  logic signed [10:0] ay0 = '0;
  logic signed [10:0] bx0 = '0;
  logic signed [10:0] by0 = '0;
  logic signed [10:0] ax1 = '0;
  logic signed [10:0] ay1 = '0;
  logic signed [10:0] bx1 = '0;
  logic signed [10:0] by1 = '0;
  logic               ack0;
  logic               ack1;
  logic signed [22:0] result;
  logic               neg;
  logic               zero;
  logic               busy;

  int checks = 0;
  int passes = 0;

  cross_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req0   (req0),
    .req1   (req1),
    .ax0    (ax0),
    .ay0    (ay0),
    .bx0    (bx0),
    .by0    (by0),
    .ax1    (ax1),
    .ay1    (ay1),
    .bx1    (bx1),
    .by1    (by1),
    .ack0   (ack0),
    .ack1   (ack1),
    .result (result),
    .neg    (neg),
    .zero   (zero),
    .busy   (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic driveOperands(input int which, input int ax, input int ay, input int bx, input int by);
    if (which == 0) begin
      ax0 = 11'(ax); ay0 = 11'(ay); bx0 = 11'(bx); by0 = 11'(by);
    end else begin
      ax1 = 11'(ax); ay1 = 11'(ay); bx1 = 11'(bx); by1 = 11'(by);
    end
  endtask

  task automatic waitAck(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!(ack0 || ack1) && cycles < 12);
  endtask

  // One complete service for a single requester, checked end to end.
  task automatic applyStimulus(input string tag, input int which, input int ax, input int ay,
                               input int bx, input int by, input int expResult);
    int cycles;
    driveOperands(which, ax, ay, bx, by);
    if (which == 0) req0 = 1'b1; else req1 = 1'b1;
    waitAck(cycles);
    checkOutput({tag, "_latency"}, cycles, 3);
    checkOutput({tag, "_ack"}, int'(which == 0 ? ack0 : ack1), 1);
    checkOutput({tag, "_other_ack"}, int'(which == 0 ? ack1 : ack0), 0);
    checkOutput({tag, "_result"}, int'(result), expResult);
    checkOutput({tag, "_neg"}, int'(neg), int'(expResult < 0));
    checkOutput({tag, "_zero"}, int'(zero), int'(expResult == 0));
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    checkOutput({tag, "_ack_pulse"}, int'(ack0 | ack1), 0);
    checkOutput({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  // Both requesters asking; grants must alternate starting with 0.
  // Requester 0 yields 13 and requester 1 yields -2 with the operands used.
  task automatic runPair(input string tag, input int services, input bit dropOnAck);
    int cyc = 0;
    int lastCyc = 0;
    int n = 0;
    int g;
    bit both = 1'b0;
    driveOperands(0, 3, 1, 2, 5);
    driveOperands(1, 1, 2, 3, 4);
    req0 = 1'b1;
    req1 = 1'b1;
    while (n < services && cyc < services * 4 + 12) begin
      step();
      cyc++;
      if (ack0 && ack1) both = 1'b1;
      if (ack0 || ack1) begin
        g = ack1 ? 1 : 0;
        checkOutput($sformatf("%s_grant%0d", tag, n), g, n % 2);
        checkOutput($sformatf("%s_result%0d", tag, n), int'(result), (g == 0) ? 13 : -2);
        if (n > 0) checkOutput($sformatf("%s_gap%0d", tag, n), cyc - lastCyc, 4);
        lastCyc = cyc;
        n++;
        if (dropOnAck) begin
          if (g == 0) req0 = 1'b0; else req1 = 1'b0;
        end
        if (n == services) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
    end
    checkOutput({tag, "_count"}, n, services);
    checkOutput({tag, "_both_acks"}, int'(both), 0);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    step();
    step();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ack0", int'(ack0), 0);
    checkOutput("rst_ack1", int'(ack1), 0);
    checkOutput("rst_result", int'(result), 0);
    checkOutput("rst_neg", int'(neg), 0);
    checkOutput("rst_zero", int'(zero), 1);
    reset = 1'b0;
    step();

    // Single request: 3*5 - 1*2 = 13.
    applyStimulus("single", 0, 3, 1, 2, 5, 13);

    // Tie right after reset-like pointer state: 0 first, then 1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    runPair("tie", 2, 1'b1);

    // Continuous round-robin for six services.
    runPair("rr", 6, 1'b0);

    // Extremes.
    applyStimulus("ext_pos", 0, -1024, 1023, -1024, -1024, 2096128);
    applyStimulus("ext_neg", 0, -1024, -1024, -1024, 1023, -2096128);

    // Collinear operands give zero.
    applyStimulus("zero", 1, 2, 4, 3, 6, 0);

    // Operands changed during MUL1 must not disturb the result.
    driveOperands(0, 3, 1, 2, 5);
    req0 = 1'b1;
    step();
    checkOutput("stab_busy", int'(busy), 1);
    driveOperands(0, -500, 400, 300, -200);
    step();
    step();
    checkOutput("stab_ack0", int'(ack0), 1);
    checkOutput("stab_result", int'(result), 13);
    checkOutput("stab_zero", int'(zero), 0);
    req0 = 1'b0;
    step();

    // Reset while in MUL2 aborts the service: 7*4 - 2*3 = 22 never acked.
    driveOperands(1, 7, 2, 3, 4);
    req1 = 1'b1;
    step();
    step();
    reset = 1'b1;
    req1 = 1'b0;
    step();
    checkOutput("midrst_ack0", int'(ack0), 0);
    checkOutput("midrst_ack1", int'(ack1), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_result", int'(result), 0);
    checkOutput("midrst_zero", int'(zero), 1);
    reset = 1'b0;
    step();
    checkOutput("midrst_no_late_ack", int'(ack0 | ack1), 0);
    applyStimulus("post_rst", 1, 7, 2, 3, 4, 22);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
